// File: rtl/krp_pkg.sv
// krp_pkg: shared KRP core widths, reset vector and NOP encoding
package krp_pkg;
    localparam int          KRP_XLEN     = 32;
    localparam int          KRP_WADDR_W  = 30;
    localparam logic [31:0] KRP_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KRP_NOP      = 32'h0000_0013;
endpackage

// File: rtl/krp_ifetch_fifo.sv
// krp_ifetch_fifo: sync fetch buffer with flush; flush beats push, push+pop same cycle allowed
module krp_ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 62,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd, wr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // storage cleared on reset so the head reads zero until the first push
    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= nxt(wr);
            end
            if (pop) rd <= nxt(rd);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout = mem[rd];
endmodule

// File: rtl/krp_ifetch.sv
// krp_ifetch: PC owner, credit-limited SRAM fetch issue, redirect squash, buffered decode output
module krp_ifetch
    import krp_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = KRP_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ireq,
    output logic [KRP_WADDR_W-1:0] iaddr,
    input  logic [KRP_XLEN-1:0]    instr,
    input  logic                   redirect,
    input  logic [KRP_WADDR_W-1:0] redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [KRP_XLEN-1:0]    out_instr,
    output logic [KRP_WADDR_W-1:0] out_pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [KRP_WADDR_W-1:0] RESET_WA = RESET_PC[31:2];

    logic [KRP_WADDR_W-1:0]          pc, inflight_pc;
    logic                            inflight, rst_d, pop;
    logic [CW-1:0]                   count;
    logic [CW:0]                     need;
    logic [KRP_WADDR_W+KRP_XLEN-1:0] head;

    assign pop       = out_valid & out_ready;
    assign need      = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    assign ireq      = ~rst & ~rst_d & ~redirect & (need < (CW + 1)'(FIFO_DEPTH));
    assign iaddr     = rst ? RESET_WA : pc;
    assign out_valid = count != '0;
    assign out_pc    = head[KRP_WADDR_W+KRP_XLEN-1:KRP_XLEN];
    assign out_instr = head[KRP_XLEN-1:0];

    // PC advance and in-flight tracking; redirect squashes the outstanding read
    always_ff @(posedge clk) begin
        rst_d <= rst;
        if (rst) begin
            pc          <= RESET_WA;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= ireq;
            if (ireq) begin
                pc          <= pc + 30'd1;
                inflight_pc <= pc;
            end
        end
    end

    krp_ifetch_fifo #(.DEPTH(FIFO_DEPTH), .W(KRP_WADDR_W + KRP_XLEN)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight & ~redirect),
        .pop   (pop),
        .flush (redirect),
        .din   ({inflight_pc, instr}),
        .dout  (head),
        .count (count)
    );
endmodule

// File: tb/tb_krp_ifetch.sv
// tb_krp_ifetch: directed fetch scenarios with an expected-PC scoreboard on output transfers
module tb_krp_ifetch;
    logic        clk = 1'b0;
    logic        rst, ireq, redirect, out_valid, out_ready;
    logic [29:0] iaddr, redirect_pc, out_pc;
    logic [31:0] instr, out_instr;
    logic [29:0] q[$];
    int          tests = 0;
    int          fails = 0;

    krp_ifetch dut (
        .clk(clk), .rst(rst), .ireq(ireq), .iaddr(iaddr), .instr(instr),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    // instruction SRAM: one-cycle synchronous read, 1K words aliased
    always @(posedge clk) if (ireq) instr <= 32'hA000_0000 + {22'd0, iaddr[9:0]};

    function automatic logic [31:0] exp_instr(input logic [29:0] pc);
        return 32'hA000_0000 + {22'd0, pc[9:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_from(input logic [29:0] start, input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(start + 30'(i));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every accepted output must be the next expected PC and its word
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL xfer_extra: got pc %h expected no transfer", out_pc);
            end else begin
                logic [29:0] e;
                e = q.pop_front();
                check("xfer_pc", {2'b0, out_pc}, {2'b0, e});
                check("xfer_instr", out_instr, exp_instr(e));
            end
        end
    end

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        expect_from(30'd0, 64);
        repeat (10) cyc();
        check("rst_ireq", 32'(ireq), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_iaddr", 32'(iaddr), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        rst = 1'b0; #1;
        check("post_rst_ireq", 32'(ireq), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        cyc();
        check("first_ireq", 32'(ireq), 32'd1);
        check("first_iaddr", 32'(iaddr), 32'd0);
        cyc();
        check("lat_valid", 32'(out_valid), 32'd0);
        check("second_iaddr", 32'(iaddr), 32'd1);
        cyc();
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc", 32'(out_pc), 32'(i));
            check("stream_instr", out_instr, exp_instr(30'(i)));
            cyc();
        end
        out_ready = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_pc", 32'(out_pc), 32'd8);
            check("bp_ireq", 32'(ireq), 32'd0);
            check("bp_iaddr", 32'(iaddr), 32'd10);
            cyc();
        end
        out_ready = 1'b1; #1;
        check("bp_rel_ireq", 32'(ireq), 32'd1);
        check("bp_rel_iaddr", 32'(iaddr), 32'd10);
        for (int i = 8; i < 12; i++) begin
            check("bp_rel_valid", 32'(out_valid), 32'd1);
            check("bp_rel_pc", 32'(out_pc), 32'(i));
            cyc();
        end
        redirect = 1'b1; redirect_pc = 30'h40; #1;
        check("redir_ireq", 32'(ireq), 32'd0);
        cyc();
        redirect = 1'b0;
        expect_from(30'h40, 16); #1;
        check("redir_flush_valid", 32'(out_valid), 32'd0);
        check("redir_ireq_t1", 32'(ireq), 32'd1);
        check("redir_iaddr_t1", 32'(iaddr), 32'h40);
        cyc();
        check("redir_valid_t2", 32'(out_valid), 32'd0);
        cyc();
        check("redir_valid_t3", 32'(out_valid), 32'd1);
        check("redir_pc_t3", 32'(out_pc), 32'h40);
        check("redir_instr_t3", out_instr, 32'hA000_0040);
        cyc();
        check("redir_pc_t4", 32'(out_pc), 32'h41);
        redirect = 1'b1; redirect_pc = 30'h100;
        cyc();
        redirect_pc = 30'h3FFF_FFFF; #1;
        check("b2b_ireq", 32'(ireq), 32'd0);
        check("b2b_valid", 32'(out_valid), 32'd0);
        cyc();
        redirect = 1'b0;
        expect_from(30'h3FFF_FFFF, 16); #1;
        check("wrap_iaddr", 32'(iaddr), 32'h3FFF_FFFF);
        check("wrap_ireq", 32'(ireq), 32'd1);
        cyc();
        cyc();
        check("wrap_pc_top", 32'(out_pc), 32'h3FFF_FFFF);
        check("wrap_instr_top", out_instr, 32'hA000_03FF);
        cyc();
        check("wrap_pc_zero", 32'(out_pc), 32'd0);
        check("wrap_instr_zero", out_instr, 32'hA000_0000);
        cyc();
        check("wrap_pc_one", 32'(out_pc), 32'd1);
        out_ready = 1'b0;
        repeat (4) cyc();
        check("full_ireq", 32'(ireq), 32'd0);
        check("full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        expect_from(30'd0, 16);
        cyc();
        cyc();
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_ireq", 32'(ireq), 32'd0);
        check("mrst_iaddr", 32'(iaddr), 32'd0);
        rst = 1'b0; out_ready = 1'b1; #1;
        check("mrst_post_ireq", 32'(ireq), 32'd0);
        check("mrst_post_iaddr", 32'(iaddr), 32'd0);
        check("mrst_post_valid", 32'(out_valid), 32'd0);
        cyc();
        check("mrst_first_ireq", 32'(ireq), 32'd1);
        check("mrst_first_iaddr", 32'(iaddr), 32'd0);
        cyc();
        cyc();
        check("mrst_out_valid", 32'(out_valid), 32'd1);
        check("mrst_out_pc", 32'(out_pc), 32'd0);
        check("mrst_out_instr", out_instr, 32'hA000_0000);
        cyc();
        check("mrst_out_pc1", 32'(out_pc), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
